clk_div_controller: RTL

//  Runtime-programmable clock-enable scheduler for the VGA pixel/timing path.

---
 rtl/clk_div_controller.sv | 137 +++++++++++++
 1 files changed

// File: rtl/clk_div_controller.sv
// Programmable tick/clock-enable divider; ratio changes land on period boundaries.
// Optional CLKDIV_CTRL_TICKCNT_EN adds a free-running 16-bit tick_count output.
module clk_div_controller #(
    parameter int unsigned      DIV_W       = 8,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(2)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             tick,
    output logic             clk_out,
    output logic [DIV_W-1:0] cur_div,
`ifdef CLKDIV_CTRL_TICKCNT_EN
    output logic [15:0]      tick_count,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] count, count_n;
    logic [DIV_W-1:0] cur_div_n;
    logic [DIV_W-1:0] pend_div, pend_div_n;
    logic             tick_n, clk_out_n, ready_n, busy_n;
    logic             xfer, bound;

    assign xfer  = cfg_valid & cfg_ready;
    assign bound = (count == cur_div);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= STOP;
            count     <= '0;
            cur_div   <= DEFAULT_DIV;
            pend_div  <= DEFAULT_DIV;
            tick      <= 1'b0;
            clk_out   <= 1'b0;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            cur_div   <= cur_div_n;
            pend_div  <= pend_div_n;
            tick      <= tick_n;
            clk_out   <= clk_out_n;
            cfg_ready <= ready_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n    = state;
        count_n    = count;
        cur_div_n  = cur_div;
        pend_div_n = pend_div;
        tick_n     = 1'b0;
        clk_out_n  = clk_out;
        ready_n    = cfg_ready;
        busy_n     = busy;
        unique case (state)
            STOP: begin
                count_n   = '0;
                clk_out_n = 1'b0;
                if (xfer)
                    cur_div_n = cfg_div;
                if (enable)
                    state_n = RUN;
            end
            RUN: begin
                if (!enable) begin
                    // accepted word is applied directly since we stop anyway
                    state_n   = STOP;
                    count_n   = '0;
                    clk_out_n = 1'b0;
                    if (xfer)
                        cur_div_n = cfg_div;
                end else begin
                    if (bound) begin
                        count_n   = '0;
                        tick_n    = 1'b1;
                        clk_out_n = ~clk_out;
                    end else begin
                        count_n = count + DIV_W'(1);
                    end
                    if (xfer) begin
                        pend_div_n = cfg_div;
                        ready_n    = 1'b0;
                        busy_n     = 1'b1;
                        state_n    = PEND;
                    end
                end
            end
            PEND: begin
                if (!enable) begin
                    state_n   = STOP;
                    count_n   = '0;
                    clk_out_n = 1'b0;
                    cur_div_n = pend_div;
                    ready_n   = 1'b1;
                    busy_n    = 1'b0;
                end else if (bound) begin
                    count_n   = '0;
                    tick_n    = 1'b1;
                    clk_out_n = ~clk_out;
                    cur_div_n = pend_div;
                    ready_n   = 1'b1;
                    busy_n    = 1'b0;
                    state_n   = RUN;
                end else begin
                    count_n = count + DIV_W'(1);
                end
            end
            default: begin
                state_n = STOP;
            end
        endcase
    end

`ifdef CLKDIV_CTRL_TICKCNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            tick_count <= '0;
        else if (tick_n)
            tick_count <= tick_count + 16'd1;
    end
`endif

endmodule
